// File: rtl/ep2_guard_pkg.sv
// Shared definitions for the guard family: FSM state encoding and the
// meaning of a select token.
package ep2_guard_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        FORWARD = 1'b1
    } guard_state_e;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry AXI-Stream register slice: an output register backed by one skid
// entry, so upstream ready is registered and throughput stays at one beat/cycle.
module axis_skid_reg #(
    parameter int DATA_WIDTH = 16,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);

    localparam int BeatWidth = DATA_WIDTH + KEEP_WIDTH + 1;

    logic [BeatWidth-1:0] out_q;
    logic [BeatWidth-1:0] skid_q;
    logic [BeatWidth-1:0] in_beat;
    logic                 out_valid_q;
    logic                 skid_valid_q;

    assign in_beat = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};

    // The skid entry only fills while the output entry is occupied, so a
    // busy skid entry means both are full.
    assign s_axis_tready = rst_n & ~skid_valid_q;

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = out_q;
    assign m_axis_tvalid = rst_n & out_valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (!out_valid_q || m_axis_tready) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= s_axis_tvalid;
                if (s_axis_tvalid) begin
                    out_q <= in_beat;
                end
            end
        end else if (s_axis_tvalid && s_axis_tready) begin
            skid_q       <= in_beat;
            skid_valid_q <= 1'b1;
        end
    end

endmodule

// File: rtl/guard_merge.sv
// Rejoins frames split by upstream guards: each select token forwards one whole
// frame from input A or B, in token order, through a two-entry skid register.
module guard_merge
    import ep2_guard_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int IF_STREAM  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_merge_cond_tdata,
    input  logic                  s_merge_cond_tvalid,
    output logic                  s_merge_cond_tready,
    input  logic [DATA_WIDTH-1:0] s_merge_a_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_merge_a_axis_tkeep,
    input  logic                  s_merge_a_axis_tlast,
    input  logic                  s_merge_a_axis_tvalid,
    output logic                  s_merge_a_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_merge_b_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_merge_b_axis_tkeep,
    input  logic                  s_merge_b_axis_tlast,
    input  logic                  s_merge_b_axis_tvalid,
    output logic                  s_merge_b_axis_tready,
    output logic [DATA_WIDTH-1:0] m_merge_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_merge_axis_tkeep,
    output logic                  m_merge_axis_tlast,
    output logic                  m_merge_axis_tvalid,
    input  logic                  m_merge_axis_tready
);

    guard_state_e state_q, state_d;
    logic         sel_q, sel_d;

    logic [DATA_WIDTH-1:0] skid_tdata;
    logic [KEEP_WIDTH-1:0] skid_tkeep;
    logic                  skid_tlast;
    logic                  skid_tvalid;
    logic                  skid_tready;

    logic                  a_last_eff, b_last_eff;
    logic [KEEP_WIDTH-1:0] a_keep_eff, b_keep_eff;

    // Token mode: every beat is a complete frame with all bytes valid.
    assign a_last_eff = (IF_STREAM != 0) ? s_merge_a_axis_tlast : 1'b1;
    assign b_last_eff = (IF_STREAM != 0) ? s_merge_b_axis_tlast : 1'b1;
    assign a_keep_eff = (IF_STREAM != 0) ? s_merge_a_axis_tkeep : {KEEP_WIDTH{1'b1}};
    assign b_keep_eff = (IF_STREAM != 0) ? s_merge_b_axis_tkeep : {KEEP_WIDTH{1'b1}};

    always_comb begin
        state_d               = state_q;
        sel_d                 = sel_q;
        s_merge_cond_tready   = 1'b0;
        s_merge_a_axis_tready = 1'b0;
        s_merge_b_axis_tready = 1'b0;
        skid_tvalid           = 1'b0;
        skid_tdata            = s_merge_a_axis_tdata;
        skid_tkeep            = a_keep_eff;
        skid_tlast            = a_last_eff;
        unique case (state_q)
            IDLE: begin
                s_merge_cond_tready = rst_n;
                if (rst_n && s_merge_cond_tvalid) begin
                    sel_d   = s_merge_cond_tdata;
                    state_d = FORWARD;
                end
            end
            FORWARD: begin
                if (sel_q == SEL_A) begin
                    s_merge_a_axis_tready = skid_tready;
                    skid_tvalid           = s_merge_a_axis_tvalid;
                    if (s_merge_a_axis_tvalid && skid_tready && a_last_eff) begin
                        state_d = IDLE;
                    end
                end else begin
                    s_merge_b_axis_tready = skid_tready;
                    skid_tvalid           = s_merge_b_axis_tvalid;
                    skid_tdata            = s_merge_b_axis_tdata;
                    skid_tkeep            = b_keep_eff;
                    skid_tlast            = b_last_eff;
                    if (s_merge_b_axis_tvalid && skid_tready && b_last_eff) begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= SEL_B;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    axis_skid_reg #(
        .DATA_WIDTH(DATA_WIDTH),
        .KEEP_WIDTH(KEEP_WIDTH)
    ) u_skid (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis_tdata (skid_tdata),
        .s_axis_tkeep (skid_tkeep),
        .s_axis_tlast (skid_tlast),
        .s_axis_tvalid(skid_tvalid),
        .s_axis_tready(skid_tready),
        .m_axis_tdata (m_merge_axis_tdata),
        .m_axis_tkeep (m_merge_axis_tkeep),
        .m_axis_tlast (m_merge_axis_tlast),
        .m_axis_tvalid(m_merge_axis_tvalid),
        .m_axis_tready(m_merge_axis_tready)
    );

endmodule

// File: tb/tb_guard_merge.sv
// Bench for guard_merge: directed scenarios plus random traffic checked against
// a token-order frame queue model, for both stream and token-mode instances.
module tb_guard_merge;

    localparam int DW = 16;
    localparam int KW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cond_tdata, cond_tvalid;
    logic [DW-1:0] a_tdata, b_tdata;
    logic [KW-1:0] a_tkeep, b_tkeep;
    logic          a_tlast, b_tlast, a_tvalid, b_tvalid, m_tready;

    logic          s_cond_tready, s_a_tready, s_b_tready, s_m_tlast, s_m_tvalid;
    logic [DW-1:0] s_m_tdata;
    logic [KW-1:0] s_m_tkeep;
    logic          t_cond_tready, t_a_tready, t_b_tready, t_m_tlast, t_m_tvalid;
    logic [DW-1:0] t_m_tdata;
    logic [KW-1:0] t_m_tkeep;

    logic          tok_mode;
    logic          cond_tready, a_tready, b_tready, m_tlast, m_tvalid;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;

    always_comb begin
        cond_tready = tok_mode ? t_cond_tready : s_cond_tready;
        a_tready    = tok_mode ? t_a_tready : s_a_tready;
        b_tready    = tok_mode ? t_b_tready : s_b_tready;
        m_tdata     = tok_mode ? t_m_tdata : s_m_tdata;
        m_tkeep     = tok_mode ? t_m_tkeep : s_m_tkeep;
        m_tlast     = tok_mode ? t_m_tlast : s_m_tlast;
        m_tvalid    = tok_mode ? t_m_tvalid : s_m_tvalid;
    end

    guard_merge #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .IF_STREAM(1)) dut_stream (
        .clk(clk), .rst_n(rst_n),
        .s_merge_cond_tdata(cond_tdata), .s_merge_cond_tvalid(cond_tvalid),
        .s_merge_cond_tready(s_cond_tready),
        .s_merge_a_axis_tdata(a_tdata), .s_merge_a_axis_tkeep(a_tkeep),
        .s_merge_a_axis_tlast(a_tlast), .s_merge_a_axis_tvalid(a_tvalid),
        .s_merge_a_axis_tready(s_a_tready),
        .s_merge_b_axis_tdata(b_tdata), .s_merge_b_axis_tkeep(b_tkeep),
        .s_merge_b_axis_tlast(b_tlast), .s_merge_b_axis_tvalid(b_tvalid),
        .s_merge_b_axis_tready(s_b_tready),
        .m_merge_axis_tdata(s_m_tdata), .m_merge_axis_tkeep(s_m_tkeep),
        .m_merge_axis_tlast(s_m_tlast), .m_merge_axis_tvalid(s_m_tvalid),
        .m_merge_axis_tready(m_tready)
    );

    guard_merge #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .IF_STREAM(0)) dut_token (
        .clk(clk), .rst_n(rst_n),
        .s_merge_cond_tdata(cond_tdata), .s_merge_cond_tvalid(cond_tvalid),
        .s_merge_cond_tready(t_cond_tready),
        .s_merge_a_axis_tdata(a_tdata), .s_merge_a_axis_tkeep(a_tkeep),
        .s_merge_a_axis_tlast(a_tlast), .s_merge_a_axis_tvalid(a_tvalid),
        .s_merge_a_axis_tready(t_a_tready),
        .s_merge_b_axis_tdata(b_tdata), .s_merge_b_axis_tkeep(b_tkeep),
        .s_merge_b_axis_tlast(b_tlast), .s_merge_b_axis_tvalid(b_tvalid),
        .s_merge_b_axis_tready(t_b_tready),
        .m_merge_axis_tdata(t_m_tdata), .m_merge_axis_tkeep(t_m_tkeep),
        .m_merge_axis_tlast(t_m_tlast), .m_merge_axis_tvalid(t_m_tvalid),
        .m_merge_axis_tready(m_tready)
    );

    // Model: token i consumes the next whole frame of its selected input.
    logic  cond_q[$];
    beat_t a_q[$];
    beat_t b_q[$];
    beat_t want_q[$];

    int    checks;
    int    errors;
    int    delivered;
    int    last_n;
    int    d0;
    logic  a_ready_seen;
    logic  hold_pending;
    beat_t held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic step(input int vp, input int rp);
        logic cf, af, bf, mf;
        cond_tvalid = (cond_q.size() != 0) && ($urandom_range(99) < vp);
        cond_tdata  = (cond_q.size() != 0) ? cond_q[0] : 1'b0;
        a_tvalid    = (a_q.size() != 0) && ($urandom_range(99) < vp);
        if (a_q.size() != 0) {a_tdata, a_tkeep, a_tlast} = a_q[0];
        b_tvalid    = (b_q.size() != 0) && ($urandom_range(99) < vp);
        if (b_q.size() != 0) {b_tdata, b_tkeep, b_tlast} = b_q[0];
        m_tready    = ($urandom_range(99) < rp);
        #1;
        a_ready_seen = a_ready_seen | a_tready;
        chk("ready_excl", 32'((cond_tready & (a_tready | b_tready)) | (a_tready & b_tready)), 32'd0);
        if (hold_pending && rst_n)
            chk("hold_stable", 32'({m_tvalid, m_tdata, m_tkeep, m_tlast}), 32'({1'b1, held}));
        hold_pending = rst_n && m_tvalid && !m_tready;
        held = {m_tdata, m_tkeep, m_tlast};
        cf = cond_tvalid && cond_tready;
        af = a_tvalid && a_tready;
        bf = b_tvalid && b_tready;
        mf = m_tvalid && m_tready;
        if (mf) begin
            chk("spurious_beat", 32'(want_q.size() != 0), 32'd1);
            if (want_q.size() != 0)
                chk("out_beat", 32'({m_tdata, m_tkeep, m_tlast}), 32'(want_q[0]));
            delivered++;
        end
        @(posedge clk);
        if (cf) void'(cond_q.pop_front());
        if (af) void'(a_q.pop_front());
        if (bf) void'(b_q.pop_front());
        if (mf && want_q.size() != 0) void'(want_q.pop_front());
        @(negedge clk);
    endtask

    task automatic run_until(input string tag, input int limit, input int vp, input int rp);
        int n;
        n = 0;
        while (want_q.size() != 0 && n < limit) begin
            step(vp, rp);
            n++;
        end
        last_n = n;
        chk({tag, "_drain"}, 32'(want_q.size()), 32'd0);
    endtask

    task automatic flush_model();
        cond_q.delete();
        a_q.delete();
        b_q.delete();
        want_q.delete();
        hold_pending = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush_model();
        step(100, 100);
        step(100, 100);
        #1;
        chk("rst_cond_ready", 32'(cond_tready), 32'd0);
        chk("rst_m_valid", 32'(m_tvalid), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_cond_ready", 32'(cond_tready), 32'd1);
        chk("post_rst_m_valid", 32'(m_tvalid), 32'd0);
        chk("post_rst_in_ready", 32'(a_tready | b_tready), 32'd0);
    endtask

    task automatic push_frame(input logic sel, input logic [DW-1:0] base, input int len);
        beat_t bt;
        cond_q.push_back(sel);
        for (int i = 0; i < len; i++) begin
            bt.data = base + DW'(i);
            bt.keep = 2'b11;
            bt.last = (i == len - 1);
            if (sel) a_q.push_back(bt);
            else b_q.push_back(bt);
            want_q.push_back(bt);
        end
    endtask

    task automatic gen_traffic(input int n_tok);
        for (int t = 0; t < n_tok; t++) begin
            logic  sel;
            int    len;
            beat_t bt, wb;
            sel = 1'($urandom_range(1));
            len = tok_mode ? 1 : int'($urandom_range(5, 1));
            cond_q.push_back(sel);
            for (int i = 0; i < len; i++) begin
                bt.data = DW'($urandom);
                bt.keep = KW'($urandom);
                bt.last = tok_mode ? 1'($urandom) : (i == len - 1);
                wb = bt;
                if (tok_mode) begin
                    wb.last = 1'b1;
                    wb.keep = 2'b11;
                end
                if (sel) a_q.push_back(bt);
                else b_q.push_back(bt);
                want_q.push_back(wb);
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0; delivered = 0; last_n = 0; d0 = 0;
        tok_mode = 1'b0; a_ready_seen = 1'b0; hold_pending = 1'b0; held = '0;
        cond_tdata = 1'b0; cond_tvalid = 1'b0; m_tready = 1'b0;
        a_tdata = '0; a_tkeep = '0; a_tlast = 1'b0; a_tvalid = 1'b0;
        b_tdata = '0; b_tkeep = '0; b_tlast = 1'b0; b_tvalid = 1'b0;
        @(negedge clk);
        do_reset();

        // Two frames back to back, full throughput with one token bubble each.
        push_frame(1'b1, 16'hA001, 3);
        push_frame(1'b0, 16'hB001, 2);
        run_until("req027", 50, 100, 100);
        chk("req027_cycles", 32'(last_n), 32'd8);

        // Unselected input must be left waiting untouched.
        push_frame(1'b0, 16'h2222, 1);
        a_q.push_back(beat_t'{data: 16'h1111, keep: 2'b11, last: 1'b1});
        a_ready_seen = 1'b0;
        run_until("req028", 50, 100, 100);
        repeat (4) step(100, 100);
        chk("req028_a_ready", 32'(a_ready_seen), 32'd0);
        chk("req028_a_waiting", 32'(a_q.size()), 32'd1);
        do_reset();

        // Output stall mid frame: two beats buffered, then input backs off.
        push_frame(1'b1, 16'hC001, 6);
        d0 = delivered;
        step(100, 100);
        step(100, 100);
        repeat (5) step(100, 0);
        chk("req029_in_stall", 32'(a_q.size()), 32'd4);
        run_until("req029", 50, 100, 100);
        chk("req029_count", 32'(delivered - d0), 32'd6);

        // Reset mid frame discards the partial frame.
        push_frame(1'b1, 16'hD001, 4);
        d0 = delivered;
        repeat (3) step(100, 100);
        chk("req031_pre", 32'(delivered - d0), 32'd1);
        rst_n = 1'b0;
        step(100, 100);
        flush_model();
        rst_n = 1'b1;
        #1;
        chk("req031_m_valid", 32'(m_tvalid), 32'd0);
        chk("req031_cond_ready", 32'(cond_tready), 32'd1);
        push_frame(1'b0, 16'hE001, 3);
        run_until("req031", 50, 100, 100);

        gen_traffic(40);
        run_until("rand_stream", 3000, 70, 60);
        chk("rand_stream_a_left", 32'(a_q.size() + b_q.size() + cond_q.size()), 32'd0);

        // Token mode: tlast/tkeep forced on every beat.
        tok_mode = 1'b1;
        do_reset();
        cond_q.push_back(1'b1);
        cond_q.push_back(1'b1);
        cond_q.push_back(1'b0);
        a_q.push_back(beat_t'{data: 16'h3001, keep: 2'b00, last: 1'b0});
        a_q.push_back(beat_t'{data: 16'h3002, keep: 2'b00, last: 1'b0});
        b_q.push_back(beat_t'{data: 16'h3003, keep: 2'b00, last: 1'b0});
        want_q.push_back(beat_t'{data: 16'h3001, keep: 2'b11, last: 1'b1});
        want_q.push_back(beat_t'{data: 16'h3002, keep: 2'b11, last: 1'b1});
        want_q.push_back(beat_t'{data: 16'h3003, keep: 2'b11, last: 1'b1});
        run_until("req030", 50, 100, 100);

        gen_traffic(30);
        run_until("rand_tok", 2000, 70, 60);
        chk("rand_tok_left", 32'(a_q.size() + b_q.size() + cond_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/guard_merge.md
GUARD_MERGE -- requirements
Module: guard_merge

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 16, beat data width; KEEP_WIDTH, default DATA_WIDTH/8, byte-enable width; IF_STREAM, default 1, 1 = multi-beat frames, 0 = single-beat tokens.
REQ-002 Ports SHALL be: clk  in  1  single clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 s_merge_cond_tdata / tvalid / tready  in / in / out  1 / 1 / 1  select token, one per output frame; 1 = take input A, 0 = take input B.
REQ-005 s_merge_a_axis_tdata / tkeep / tlast / tvalid / tready  in, in, in, in, out  DATA_WIDTH / KEEP_WIDTH / 1 / 1 / 1  input stream A.
REQ-006 s_merge_b_axis_* SHALL mirror REQ-005 as input stream B.
REQ-007 m_merge_axis_tdata / tkeep / tlast / tvalid / tready  out, out, out, out, in  DATA_WIDTH / KEEP_WIDTH / 1 / 1 / 1  merged output stream.

Function
REQ-008 Block SHALL rejoin frames split by upstream guards: per cond token it forwards exactly one whole frame from the selected input, in token order.
REQ-009 FSM states SHALL be IDLE and FORWARD; reset state IDLE.
REQ-010 In IDLE: s_merge_cond_tready = 1; both input treadys = 0; on cond handshake latch sel <= tdata, go to FORWARD next cycle.
REQ-011 In FORWARD: s_merge_cond_tready = 0; only the selected input's tready may be 1, equal to the output buffer's input-ready; unselected tready = 0.
REQ-012 In FORWARD, handshake of a beat with effective tlast = 1 on the selected input SHALL return FSM to IDLE next cycle.
REQ-013 IF_STREAM = 0: effective tlast forced 1, tkeep forced all-ones on both inputs; each beat is one frame.
REQ-014 Output SHALL pass through a 2-entry skid register: input beat accepted at cycle N appears on m_merge_axis at cycle N+1 at earliest; full throughput (1 beat/cycle) in FORWARD with tready held high.
REQ-015 Skid register SHALL never drop or duplicate a beat; while m_merge_axis_tvalid = 1 and tready = 0, tdata/tkeep/tlast SHALL stay stable.
REQ-016 Skid input-ready SHALL be 1 when at least one entry is free; when both entries full, selected input tready = 0.
REQ-017 Minimum per-frame overhead SHALL be one bubble cycle (IDLE token cycle) between frames on the input side.
REQ-018 Beats on the unselected input SHALL wait indefinitely; no timeout, no drop.
REQ-019 tdata/tkeep SHALL pass unmodified from the selected input (except REQ-013 forcing).
REQ-020 Cond tvalid arriving while in FORWARD SHALL be held off (tready = 0) until IDLE.

Reset
REQ-021 While rst_n = 0 at a clock edge: state <= IDLE, sel <= 0, both skid entries invalid.
REQ-022 Output values during and after reset: m_merge_axis_tvalid = 0, all input treadys = 0; s_merge_cond_tready = 0 while rst_n = 0, then 1 in first IDLE cycle.
REQ-023 Reset mid-frame SHALL discard buffered beats and the partial frame; no beat emitted from pre-reset state.

Structure
REQ-024 Shared package ep2_guard_pkg SHALL hold the FSM state enum (IDLE, FORWARD) and select constants SEL_A = 1, SEL_B = 0, reusable by guard blocks.
REQ-025 One sub-module SHALL exist: axis_skid_reg (2-entry register slice, parameters DATA_WIDTH, KEEP_WIDTH, same clk/rst_n).
REQ-026 Total RTL SHALL be 120-400 lines; no memories, no clock-domain crossing.

Verification
REQ-027 Tokens [1,0], A frame 3 beats 0xA001..0xA003, B frame 2 beats 0xB001..0xB002, tready = 1 -> output A001,A002,A003(tlast),B001,B002(tlast).
REQ-028 Token 0 while A presents 0x1111 and B 0x2222 (single beat each) -> only 0x2222 emitted; s_merge_a_axis_tready stays 0 throughout.
REQ-029 m_merge_axis_tready = 0 for 5 cycles mid A frame of 6 beats -> output holds stable, input stalls after 2 buffered beats, all 6 beats delivered in order, none duplicated.
REQ-030 IF_STREAM = 0, tokens [1,1,0], tlast driven 0, tkeep 0 -> three single-beat outputs, each tlast = 1, tkeep = all-ones.
REQ-031 rst_n pulsed low 1 cycle after 2nd beat of a 4-beat A frame -> m tvalid 0 next cycle, FSM IDLE, cond tready 1 in first cycle after release, next token's frame delivered intact.
